// File: rtl/distortion.sv
`default_nettype none
// ============================================================================
// Module   : distortion
// Brief    : Single-channel distortion stage (hard/soft/asymmetric clip, fuzz)
//            with saturating pre-gain and one-cycle registered output.
//            Optional dry/wet blend enabled by defining DISTORTION_MIX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module distortion #(
    parameter int THRESH     = 200000,
    parameter int MAX_OUT    = 300000,
    parameter int GAIN_SHIFT = 0
) (
    input  logic               clk_48,
    input  logic               rst_n,
    input  logic signed [31:0] x,
    output logic signed [31:0] y,
    input  logic        [3:0]  options,
    input  logic        [3:0]  en
);

    // Pre-gain width: one guard bit above the shifted 32-bit sample
    localparam int W = 33 + GAIN_SHIFT;

    localparam logic signed [W-1:0] C_SAT_POS = $signed({{(W-32){1'b0}}, 32'h7fff_ffff});
    localparam logic signed [W-1:0] C_SAT_NEG = $signed({{(W-32){1'b1}}, 32'h8000_0000});
    localparam logic signed [33:0]  C_T       = 34'(THRESH);
    localparam logic signed [33:0]  C_T_HALF  = C_T >>> 1;
    localparam logic signed [33:0]  C_MAX     = 34'(MAX_OUT);
    localparam logic signed [33:0]  C_MAG_MAX = 34'sh0_7fff_ffff;

    logic signed [W-1:0] w_x_ext;
    logic signed [W-1:0] w_x_shl;
    logic signed [31:0]  w_g;
    logic signed [33:0]  w_g_wide;
    logic signed [33:0]  w_a_raw;
    logic signed [33:0]  w_a;
    logic signed [33:0]  w_excess;
    logic signed [33:0]  w_m_raw;
    logic signed [33:0]  w_m;
    logic signed [31:0]  w_wet;
    logic signed [31:0]  w_eff;
    logic                w_mode_valid;
    logic signed [31:0]  w_y_next;
    logic signed [31:0]  r_y;
    logic                w_unused_en;

    assign w_unused_en = ^en[2:0];

    // Saturating pre-gain
    assign w_x_ext = W'(x);
    assign w_x_shl = w_x_ext <<< GAIN_SHIFT;

    always_comb begin
        w_g = 32'(w_x_shl);
        if (w_x_shl > C_SAT_POS) begin
            w_g = 32'sh7fff_ffff;
        end else if (w_x_shl < C_SAT_NEG) begin
            w_g = 32'sh8000_0000;
        end
    end

    // Magnitude with |-2^31| pinned to 2^31-1
    assign w_g_wide = 34'(w_g);
    assign w_a_raw  = (w_g_wide < 0) ? -w_g_wide : w_g_wide;
    assign w_a      = (w_a_raw > C_MAG_MAX) ? C_MAG_MAX : w_a_raw;

    assign w_excess = w_a - C_T;
    assign w_m_raw  = C_T + (w_excess >>> 2);
    assign w_m      = (w_m_raw > C_MAX) ? C_MAX : w_m_raw;

    always_comb begin
        w_wet        = w_g;
        w_mode_valid = 1'b1;
        case (options)
            4'b1000: begin
                if (w_g_wide > C_T) begin
                    w_wet = 32'(C_T);
                end else if (w_g_wide < -C_T) begin
                    w_wet = 32'(-C_T);
                end
            end
            4'b0100: begin
                if (w_a > C_T) begin
                    w_wet = (w_g_wide < 0) ? 32'(-w_m) : 32'(w_m);
                end
            end
            4'b0010: begin
                if (w_g_wide > C_T) begin
                    w_wet = 32'(C_T);
                end else if (w_g_wide < -C_T_HALF) begin
                    w_wet = 32'(-C_T_HALF);
                end
            end
            4'b0001: begin
                if (w_g_wide > 0) begin
                    w_wet = 32'(C_T);
                end else if (w_g_wide < 0) begin
                    w_wet = 32'(-C_T);
                end else begin
                    w_wet = '0;
                end
            end
            default: begin
                w_mode_valid = 1'b0;
            end
        endcase
    end

`ifdef DISTORTION_MIX_EN
    // 33-bit sum keeps the blend exact; >>> rounds toward -inf
    logic signed [32:0] w_sum;
    assign w_sum = 33'(x) + 33'(w_wet);
    assign w_eff = w_sum[32:1];
`else
    assign w_eff = w_wet;
`endif

    assign w_y_next = (en[3] && w_mode_valid) ? w_eff : x;

    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_next;
        end
    end

    assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_distortion.sv
`default_nettype none
// ============================================================================
// Module   : tb_distortion
// Brief    : Scoreboard bench for distortion: expected outputs are queued as
//            stimulus is captured and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_distortion;

    localparam longint C_T    = 200000;
    localparam longint C_MAX  = 300000;
    localparam int     C_GAIN = 0;

    logic               clk_48;
    logic               rst_n;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic        [3:0]  options;
    logic        [3:0]  en;

    logic               r_stim_valid;
    logic               r_done;
    int                 checks;
    int                 errors;
    int                 tag_cnt;

    typedef struct {
        logic signed [31:0] exp;
        int                 tag;
    } exp_t;

    exp_t exp_q[$];

    distortion #(
        .THRESH    (200000),
        .MAX_OUT   (300000),
        .GAIN_SHIFT(C_GAIN)
    ) u_dut (
        .clk_48 (clk_48),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .options(options),
        .en     (en)
    );

    initial clk_48 = 1'b0;
    always #10 clk_48 = ~clk_48;

    // Reference computed from the clipping rules in plain 64-bit arithmetic
    function automatic logic signed [31:0] ref_model(input logic signed [31:0] xv,
                                                     input logic [3:0] o,
                                                     input logic [3:0] e,
                                                     input logic rn);
        longint xs, g, a, m, wet, res;
        xs = longint'(xv);
        if (!rn) return 32'sd0;
        if (!e[3] || $countones(o) != 1) return xv;
        g = xs * (longint'(1) << C_GAIN);
        if (g > 64'sd2147483647)  g = 64'sd2147483647;
        if (g < -64'sd2147483648) g = -64'sd2147483648;
        a = (g < 0) ? -g : g;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        case (o)
            4'b1000: wet = (g > C_T) ? C_T : ((g < -C_T) ? -C_T : g);
            4'b0100: begin
                if (a <= C_T) begin
                    wet = g;
                end else begin
                    m = C_T + (a - C_T) / 4;
                    if (m > C_MAX) m = C_MAX;
                    wet = (g < 0) ? -m : m;
                end
            end
            4'b0010: wet = (g > C_T) ? C_T : ((g < -(C_T / 2)) ? -(C_T / 2) : g);
            default: wet = (g > 0) ? C_T : ((g < 0) ? -C_T : 0);
        endcase
`ifdef DISTORTION_MIX_EN
        res = (xs + wet) >>> 1;
`else
        res = wet;
`endif
        return 32'(res);
    endfunction

    // Capture: whatever the DUT samples at this edge defines the next output
    always @(posedge clk_48) begin
        if (r_stim_valid) begin
            exp_q.push_back('{exp: ref_model(x, options, en, rst_n), tag: tag_cnt});
            tag_cnt = tag_cnt + 1;
        end
    end

    // Monitor: output registered at the posedge is stable by the negedge
    always @(negedge clk_48) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (y !== e.exp) begin
                errors = errors + 1;
                $display("FAIL y[%0d]: got %0d expected %0d", e.tag, y, e.exp);
            end
        end
    end

    task automatic drive(input logic signed [31:0] xv, input logic [3:0] o,
                         input logic [3:0] e);
        x       = xv;
        options = o;
        en      = e;
        @(posedge clk_48);
        #1;
    endtask

    localparam int N_DIR = 21;
    logic signed [31:0] dir_x   [N_DIR] = '{
        32'sd500000, 32'sd150000, -32'sd300000,
        32'sd400000, 32'sd200000, -32'sd400000, 32'sd2000000, 32'sh8000_0000,
        32'sd250000, -32'sd300000, -32'sd50000,
        32'sd5, -32'sd1, 32'sd0,
        32'sd123456, 32'sd123456, 32'sd123456,
        32'sd400000, 32'sd400000, 32'sh7fff_ffff, 32'sh8000_0000};
    logic [3:0] dir_opt [N_DIR] = '{
        4'b1000, 4'b1000, 4'b1000,
        4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
        4'b0010, 4'b0010, 4'b0010,
        4'b0001, 4'b0001, 4'b0001,
        4'b1000, 4'b0000, 4'b1100,
        4'b1000, 4'b0100, 4'b1000, 4'b0010};
    logic [3:0] dir_en  [N_DIR] = '{
        4'b1000, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1000,
        4'b0000, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1111, 4'b1000};

    logic [3:0] opt_tab [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                 4'b0000, 4'b1100, 4'b1111, 4'b0011};

    initial begin
        checks       = 0;
        errors       = 0;
        tag_cnt      = 0;
        r_done       = 1'b0;
        rst_n        = 1'b0;
        x            = 32'sd500000;
        options      = 4'b1000;
        en           = 4'b1000;
        r_stim_valid = 1'b1;

        repeat (3) @(posedge clk_48);
        #1;
        rst_n = 1'b1;
        drive(32'sd500000, 4'b1000, 4'b1000);

        for (int i = 0; i < N_DIR; i++) begin
            drive(dir_x[i], dir_opt[i], dir_en[i]);
        end

        for (int i = 0; i < 300; i++) begin
            logic signed [31:0] rx;
            logic [3:0]         ren;
            case ($urandom_range(0, 3))
                0:       rx = $signed($urandom);
                1:       rx = 32'sh8000_0000;
                default: rx = $signed(32'($urandom_range(0, 1600000))) - 32'sd800000;
            endcase
            ren = 4'($urandom);
            if ($urandom_range(0, 3) != 0) ren[3] = 1'b1;
            drive(rx, opt_tab[$urandom_range(0, 7)], ren);
        end

        r_stim_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk_48);
        end
        #1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
